// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial WIDTH-bit adder controller. A single one-bit full adder cell
// (fulladd) is stepped over the operands one bit per clock, LSB first. This
// block owns the operand shift registers, the carry flip-flop, the bit counter
// and the start/done handshake. {cout, sum} = a + b + cin.
//
// Parameters:
//   WIDTH  operand/sum width in bits, 1..32 (default 8)
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high; aborts an add in progress
//   start  in   request, only looked at in IDLE
//   a, b   in   WIDTH-bit operands, captured on the accepted start edge
//   cin    in   carry-in, captured on the accepted start edge
//   busy   out  high for the WIDTH cycles of the add
//   done   out  one-cycle completion pulse
//   sum    out  WIDTH-bit result, held until the next accepted start
//   cout   out  final carry-out, held like sum
//   ovf    out  (only with SERIAL_ADDER_OVF_EN) two's-complement overflow
//
// Build option:
//   `define SERIAL_ADDER_OVF_EN to add the ovf output and its register.
// -----------------------------------------------------------------------------

// One-bit full adder cell shared by the serial datapath.
module fulladd (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic s,
   output logic c
);
   assign s = x ^ y ^ z;
   assign c = (x & y) | (z & (x ^ y));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   // One extra counter bit so the count never wraps, even at WIDTH=32.
   localparam int            CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic             fa_s, fa_c;
   logic [WIDTH-1:0] sum_shift;

   fulladd u_fa (
      .x (a_sh_q[0]),
      .y (b_sh_q[0]),
      .z (carry_q),
      .s (fa_s),
      .c (fa_c)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit i sits in sum[i].
   // The WIDTH=1 case needs its own branch because sum_q[0:1] is not a slice.
   generate
      if (WIDTH == 1) begin : g_sum_w1
         assign sum_shift = fa_s;
      end else begin : g_sum_wn
         assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      // NOTE: every next-state value gets a default before the case so no
      // path leaves a signal unassigned, which would infer a latch.
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      busy_d  = busy_q;
      done_d  = done_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               sum_d   = '0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            carry_d = fa_c;
            sum_d   = sum_shift;
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               cout_d  = fa_c;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
`ifdef SERIAL_ADDER_OVF_EN
               // carry_q is the carry into the MSB, fa_c the carry out of it.
               ovf_d   = carry_q ^ fa_c;
`endif
            end
         end

         S_DONE: begin
            done_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1. Each issued
// add pushes its expected {ovf, cout, sum} (computed with plain integer
// arithmetic) into a per-instance queue; a monitor pops and compares whenever
// the instance raises done. Honours SERIAL_ADDER_OVF_EN for the ovf output.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic       rst8, start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   // WIDTH=1 instance
   logic       rst1, start1, cin1, busy1, done1, cout1;
   logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf8, ovf1;
`endif

   serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst   (rst8),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf8)
`endif
   );

   serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
      .clk   (clk),
      .rst   (rst1),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .cin   (cin1),
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf1)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Expected results: bit 33 = ovf, bit 32 = cout, bits 31:0 = sum.
   logic [33:0] exp8_q[$];
   logic [33:0] exp1_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: unsigned sum for {cout,sum}, signed range test for ovf.
   function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic c);
      longint ua, ub, full, sa, sb, ss, lim;
      logic [33:0] r;
      ua   = longint'(a);
      ub   = longint'(b);
      full = ua + ub + longint'(c);
      r    = '0;
      r[31:0] = 32'(full & ((longint'(1) << w) - 1));
      r[32]   = full[w];
      sa  = a[w-1] ? ua - (longint'(1) << w) : ua;
      sb  = b[w-1] ? ub - (longint'(1) << w) : ub;
      ss  = sa + sb + longint'(c);
      lim = longint'(1) << (w - 1);
      r[33] = (ss >= lim) || (ss < -lim);
      return r;
   endfunction

   // Monitors: compare the output whenever done is presented.
   always @(negedge clk) begin : mon8
      logic [33:0] e;
      if (done8 === 1'b1) begin
         if (exp8_q.size() == 0) begin
            check("w8_spurious_done", 64'(done8), 64'd0);
         end else begin
            e = exp8_q.pop_front();
            check("w8_sum", 64'(sum8), 64'(e[7:0]));
            check("w8_cout", 64'(cout8), 64'(e[32]));
`ifdef SERIAL_ADDER_OVF_EN
            check("w8_ovf", 64'(ovf8), 64'(e[33]));
`endif
         end
      end
   end

   always @(negedge clk) begin : mon1
      logic [33:0] e;
      if (done1 === 1'b1) begin
         if (exp1_q.size() == 0) begin
            check("w1_spurious_done", 64'(done1), 64'd0);
         end else begin
            e = exp1_q.pop_front();
            check("w1_sum", 64'(sum1), 64'(e[0]));
            check("w1_cout", 64'(cout1), 64'(e[32]));
`ifdef SERIAL_ADDER_OVF_EN
            check("w1_ovf", 64'(ovf1), 64'(e[33]));
`endif
         end
      end
   end

   // Issue one add on the WIDTH=8 instance; called at a negedge with the DUT idle.
   task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic c);
      int n;
      a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
      exp8_q.push_back(model(8, 32'(a), 32'(b), c));
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      cin8 = 1'($urandom);
      n = 0;
      while (busy8 === 1'b1 && n < 64) begin
         n++;
         @(negedge clk);
      end
      check("w8_busy_len", 64'(n), 64'd8);
      check("w8_done_hi", 64'(done8), 64'd1);
      @(negedge clk);
      check("w8_done_lo", 64'(done8), 64'd0);
   endtask

   task automatic do_add1(input logic a, input logic b, input logic c);
      int n;
      a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
      exp1_q.push_back(model(1, 32'(a), 32'(b), c));
      @(negedge clk);
      start1 = 1'b0;
      a1 = 1'($urandom);
      b1 = 1'($urandom);
      n = 0;
      while (busy1 === 1'b1 && n < 64) begin
         n++;
         @(negedge clk);
      end
      check("w1_busy_len", 64'(n), 64'd1);
      check("w1_done_hi", 64'(done1), 64'd1);
      @(negedge clk);
      check("w1_done_lo", 64'(done1), 64'd0);
   endtask

   initial begin
      int n;
      rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst8 = 1'b0;
      rst1 = 1'b0;

      // Reset state, then IDLE held for 5 edges with start low.
      check("rst_busy8", 64'(busy8), 64'd0);
      check("rst_done8", 64'(done8), 64'd0);
      check("rst_sum8", 64'(sum8), 64'd0);
      check("rst_cout8", 64'(cout8), 64'd0);
      check("rst_sum1", 64'(sum1), 64'd0);
      check("rst_busy1", 64'(busy1), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("rst_ovf8", 64'(ovf8), 64'd0);
`endif
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_busy8", 64'(busy8), 64'd0);
         check("idle_done8", 64'(done8), 64'd0);
      end

      // Directed WIDTH=8 cases.
      do_add8(8'h3C, 8'h42, 1'b0);
      do_add8(8'hFF, 8'h01, 1'b0);
      do_add8(8'hFF, 8'hFF, 1'b1);
      do_add8(8'h7F, 8'h01, 1'b0);
      do_add8(8'h80, 8'h80, 1'b0);

      // Reset on the 4th RUN edge aborts with no done pulse.
      a8 = 8'hC3; b8 = 8'h5A; cin8 = 1'b1; start8 = 1'b1;
      @(negedge clk);                    // after accept edge k
      start8 = 1'b0;
      repeat (3) @(negedge clk);         // after RUN edges k+1..k+3
      rst8 = 1'b1;
      @(negedge clk);                    // after edge k+4 (reset)
      rst8 = 1'b0;
      check("abort_busy", 64'(busy8), 64'd0);
      check("abort_done", 64'(done8), 64'd0);
      check("abort_sum", 64'(sum8), 64'd0);
      check("abort_cout", 64'(cout8), 64'd0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("abort_no_done", 64'(done8), 64'd0);
      end
      do_add8(8'h01, 8'h01, 1'b0);

      // Start held high across RUN and DONE; operand changes in RUN ignored.
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
      exp8_q.push_back(model(8, 32'h10, 32'h20, 1'b0));
      @(negedge clk);
      check("held_busy", 64'(busy8), 64'd1);
      a8 = 8'hAA; b8 = 8'h55;
      exp8_q.push_back(model(8, 32'hAA, 32'h55, 1'b0));
      n = 0;
      while (done8 !== 1'b1 && n < 64) begin
         n++;
         @(negedge clk);
      end
      check("held_first_done", 64'(done8), 64'd1);
      @(negedge clk);                    // back in IDLE
      check("held_gap_busy", 64'(busy8), 64'd0);
      @(negedge clk);                    // start accepted again
      check("held_restart_busy", 64'(busy8), 64'd1);
      start8 = 1'b0;
      n = 0;
      while (done8 !== 1'b1 && n < 64) begin
         n++;
         @(negedge clk);
      end
      check("held_second_done", 64'(done8), 64'd1);
      @(negedge clk);

      // Random WIDTH=8 traffic.
      for (int i = 0; i < 20; i++) begin
         do_add8(8'($urandom), 8'($urandom), 1'($urandom));
      end

      // WIDTH=1: plain add, mid-run reset, then add again.
      do_add1(1'b1, 1'b1, 1'b1);
      a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1; start1 = 1'b1;
      @(negedge clk);                    // after accept edge k
      start1 = 1'b0;
      rst1 = 1'b1;                       // the single RUN edge is reset
      @(negedge clk);
      rst1 = 1'b0;
      check("w1_abort_busy", 64'(busy1), 64'd0);
      check("w1_abort_done", 64'(done1), 64'd0);
      check("w1_abort_sum", 64'(sum1), 64'd0);
      check("w1_abort_cout", 64'(cout1), 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("w1_abort_no_done", 64'(done1), 64'd0);
      end
      do_add1(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         do_add1(1'($urandom), 1'($urandom), 1'($urandom));
      end

      repeat (3) @(negedge clk);
      check("w8_queue_empty", 64'(exp8_q.size()), 64'd0);
      check("w1_queue_empty", 64'(exp1_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial multi-bit adder controller. It sequences one instance of the team's one-bit full adder cell `fulladd (x, y, z, s, c)` over WIDTH-bit operands, one bit per clock, LSB first.
- It owns the operand shift registers, the carry flip-flop, the bit counter and the start/done handshake.
- It sits between a requester (test sequencer or ALU front end) and the shared single full-adder datapath.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepted start edge
- b  input  WIDTH  operand B; captured on the accepted start edge
- cin  input  1  carry-in; captured on the accepted start edge
- busy  output  1  high while the add is in progress (RUN)
- done  output  1  one-cycle completion pulse
- sum  output  WIDTH  result; holds its value until the next accepted start
- cout  output  1  final carry-out; holds its value like sum

Behaviour:
- Clocking and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, shift registers=0, carry FF=0.
- Reset priority: rst overrides everything, including mid-operation. The add in progress is aborted and produces no done pulse.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start=1 at edge k: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum<=0.
  - Same edge: busy<=1, state<=RUN.
  - start=0: remain in IDLE; sum and cout hold.
- RUN, one bit per edge:
  - Full adder inputs: x=a_sh[0], y=b_sh[0], z=carry.
  - carry<=c.
  - sum<={s, sum[WIDTH-1:1]} (shift-in at MSB, so after WIDTH shifts bit i lands in sum[i]).
  - a_sh and b_sh shift right with zero fill; cnt<=cnt+1.
- Leaving RUN:
  - On the edge where cnt==WIDTH-1, i.e. the WIDTH-th RUN edge (edge k+WIDTH), the last bit is processed.
  - Same edge: cout<=c, busy<=0, done<=1, state<=DONE.
- DONE: next edge sets done<=0, state<=IDLE.
- start handling outside IDLE:
  - start is ignored in RUN and DONE.
  - Operand changes during RUN have no effect.
  - A start held high across DONE is accepted on the first edge after return to IDLE.
- Latency and throughput:
  - done is high for exactly one cycle, following edge k+WIDTH.
  - busy is high for exactly WIDTH cycles.
  - Minimum start-to-start spacing is WIDTH+2 edges.
- Result: {cout,sum} equals a+b+cin modulo 2^(WIDTH+1).
- Counter: width is $clog2(WIDTH)+1 bits, which avoids wrap at WIDTH=32.
- WIDTH=1: RUN lasts one edge; done follows edge k+1.

Optional Feature:
- Macro: `SERIAL_ADDER_OVF_EN`.
- Defined:
  - Adds port `ovf  output  1` (two's-complement signed overflow).
  - ovf is registered on the final RUN edge as (carry into MSB) XOR (carry out of MSB), i.e. the carry FF value before the last bit XOR c.
  - Reset value 0; holds its value like sum.
- Not defined: no ovf port and no related logic. All other behaviour is identical.

Test Plan (WIDTH=8 unless noted):
1. rst=1 for 2 edges, then released with start=0 -> busy=0, done=0, sum=0x00, cout=0. State stays IDLE for 5 further edges.
2. a=0x3C, b=0x42, cin=0, start pulsed at edge k -> busy high for 8 cycles; done high for exactly the cycle after edge k+8; sum=0x7E, cout=0; ovf=0 if enabled.
3. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
4. a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
5. Start with a=0x10, b=0x20. During RUN, hold start=1 and change a=0xAA, b=0x55 -> first result is sum=0x30. Because start stays high, a second add of 0xAA+0x55 begins on the first edge after DONE and yields sum=0xFF, cout=0.
6. rst=1 on the 4th RUN edge -> after that edge busy=0, done=0, sum=0, cout=0, and no done pulse ever appears. A fresh start with a=0x01, b=0x01 then yields sum=0x02 after 8 RUN edges. Repeat the whole scenario with WIDTH=1: a=1, b=1, cin=1 -> sum=1, cout=1, done after edge k+1.
